// File: rtl/mem_access_unit.sv
// Load/store adapter between the MEM stage and a word-wide data memory; sub-word stores use read-modify-write.
// Optional range check on upper address bits is enabled by defining MAU_BOUNDS_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, WRITE} state_t;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

`ifdef MAU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_CHECK = 1'b1;
`else
  localparam logic BOUNDS_CHECK = 1'b0;
`endif

  state_t      state, state_next;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        misaligned, addr_hi_nz, reject;
  logic [31:0] byte_shift, load_val, merge_val;
  logic [15:0] half_sel;

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      OP_LW, OP_SW:         misaligned = |addr[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign addr_hi_nz = (addr >> (MEM_DEPTH_LOG2 + 2)) != '0;
  // Misaligned and out-of-range share one reject path, so both together still pulse addr_err once.
  assign reject     = misaligned || (BOUNDS_CHECK && addr_hi_nz);

  assign busy   = (state != IDLE);
  assign mem_we = (state == WRITE) && rst_n;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req && !reject) begin
          if (op == OP_SW)                    state_next = WRITE;
          else if (op == OP_SB || op == OP_SH) state_next = RMW_RD;
          else                                 state_next = LOAD;
        end
      end
      LOAD:    state_next = IDLE;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign byte_shift = mem_rdata >> {off_q, 3'b000};
  assign half_sel   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_val = mem_rdata;
    case (op_q)
      OP_LB:   load_val = {{24{byte_shift[7]}}, byte_shift[7:0]};
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LBU:  load_val = {24'h000000, byte_shift[7:0]};
      OP_LHU:  load_val = {16'h0000, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merge_val = mem_rdata;
    if (op_q == OP_SB) merge_val[{off_q, 3'b000} +: 8]         = wdata_q[7:0];
    else               merge_val[{off_q[1], 4'b0000} +: 16]    = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (reject) begin
              addr_err <= 1'b1;
            end else begin
              op_q     <= op;
              off_q    <= addr[1:0];
              wdata_q  <= wdata[15:0];
              mem_addr <= {addr[31:2], 2'b00};
              if (op == OP_SW) mem_wdata <= wdata;
            end
          end
        end
        LOAD: begin
          rdata       <= load_val;
          rdata_valid <= 1'b1;
        end
        RMW_RD:  mem_wdata <= merge_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory (combinational read, zero while writing).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, rdata_valid, addr_err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic        seeded = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH_LOG2(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .addr_err(addr_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_we ? 32'h0 : mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (!seeded) begin
      mem[0] <= 32'h11223344;
      mem[4] <= 32'h8899AABB;
      mem[5] <= 32'h00000000;
      seeded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; op = o; addr = a; wdata = d;
  endtask

  // Issues a load at the current negedge; returns at the negedge where rdata_valid is high.
  task automatic load_seq(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] exp);
    drive(o, a, 32'h0);
    @(negedge clk);
    req = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_early_valid"}, {31'b0, rdata_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'b0, rdata_valid}, 32'd1);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_rvalid"}, {31'b0, rdata_valid}, 32'd0);
    check({tag, "_aerr"}, {31'b0, addr_err}, 32'd0);
    check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_maddr"}, mem_addr, 32'h0);
    check({tag, "_mwdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; op = 3'b000; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    load_seq("lw10", 3'b010, 32'h10, 32'h8899AABB);
    check("lw10_maddr", mem_addr, 32'h10);
    // Back-to-back loads, each issued in the cycle rdata_valid is high.
    load_seq("lb13",  3'b000, 32'h13, 32'hFFFFFF88);
    load_seq("lbu13", 3'b011, 32'h13, 32'h00000088);
    load_seq("lh12",  3'b001, 32'h12, 32'hFFFF8899);
    load_seq("lhu10", 3'b100, 32'h10, 32'h0000AABB);
    @(negedge clk);
    check("hold_valid", {31'b0, rdata_valid}, 32'd0);
    check("hold_rdata", rdata, 32'h0000AABB);

    drive(3'b101, 32'h11, 32'h000000CC);
    @(negedge clk);
    req = 1'b0;
    check("sb_rd_busy", {31'b0, busy}, 32'd1);
    check("sb_rd_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check("sb_wr_we", {31'b0, mem_we}, 32'd1);
    check("sb_wr_data", mem_wdata, 32'h8899CCBB);
    @(negedge clk);
    check("sb_done_we", {31'b0, mem_we}, 32'd0);
    check("sb_done_busy", {31'b0, busy}, 32'd0);
    load_seq("lw_after_sb", 3'b010, 32'h10, 32'h8899CCBB);

    drive(3'b111, 32'h14, 32'hDEADBEEF);
    @(negedge clk);
    req = 1'b0;
    check("sw_we", {31'b0, mem_we}, 32'd1);
    check("sw_data", mem_wdata, 32'hDEADBEEF);
    check("sw_addr", mem_addr, 32'h14);
    @(negedge clk);
    check("sw_done_we", {31'b0, mem_we}, 32'd0);
    load_seq("lw_after_sw", 3'b010, 32'h14, 32'hDEADBEEF);

    drive(3'b110, 32'h12, 32'h00001234);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("sh_wr_we", {31'b0, mem_we}, 32'd1);
    check("sh_wr_data", mem_wdata, 32'h1234CCBB);
    @(negedge clk);
    load_seq("lh_after_sh", 3'b001, 32'h12, 32'h00001234);

    drive(3'b110, 32'h13, 32'h00005555);
    @(negedge clk);
    req = 1'b0;
    check("sh13_aerr", {31'b0, addr_err}, 32'd1);
    check("sh13_busy", {31'b0, busy}, 32'd0);
    check("sh13_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check("sh13_aerr_pulse", {31'b0, addr_err}, 32'd0);
    check("sh13_we2", {31'b0, mem_we}, 32'd0);
    load_seq("lw_after_sh13", 3'b010, 32'h10, 32'h1234CCBB);

    drive(3'b010, 32'h12, 32'h0);
    @(negedge clk);
    req = 1'b0;
    check("lw12_aerr", {31'b0, addr_err}, 32'd1);
    check("lw12_valid", {31'b0, rdata_valid}, 32'd0);
    @(negedge clk);
    check("lw12_aerr_pulse", {31'b0, addr_err}, 32'd0);

    drive(3'b110, 32'h10, 32'h0000BEEF);
    @(negedge clk);
    req = 1'b0;
    check("rst_rmw_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    reset_outputs("rst_rmw");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rmw_we", {31'b0, mem_we}, 32'd0);
    check("rst_rmw_mem", mem[4], 32'h1234CCBB);

    drive(3'b111, 32'h10, 32'hFFFFFFFF);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_write_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_seq("lw_after_rst_write", 3'b010, 32'h10, 32'h1234CCBB);

    drive(3'b010, 32'h1000, 32'h0);
    @(negedge clk);
    req = 1'b0;
`ifdef MAU_BOUNDS_CHECK_EN
    check("oob_aerr", {31'b0, addr_err}, 32'd1);
    check("oob_busy", {31'b0, busy}, 32'd0);
`else
    check("oob_aerr", {31'b0, addr_err}, 32'd0);
    check("oob_maddr", mem_addr, 32'h1000);
    @(negedge clk);
    check("oob_valid", {31'b0, rdata_valid}, 32'd1);
    check("oob_rdata", rdata, 32'h11223344);
`endif
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
